// File: rtl/axi_wr_pkg.sv
// Shared types for the DDR2 controller AXI write/read front ends.
package axi_wr_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI next-beat address for FIXED/INCR/WRAP bursts.
module axi_burst_addr_gen
    import axi_wr_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int ADDR_LEN   = 4
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [ADDR_LEN-1:0]   len,
    input  burst_t                burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] incr_addr;

    always_comb begin
        step      = ADDR_WIDTH'(1) << size;
        // wrap boundary is (len+1) beats of 2^size bytes
        wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        incr_addr = addr + step;
        next_addr = addr;
        case (burst)
            FIXED:   next_addr = addr;
            INCR:    next_addr = incr_addr;
            WRAP:    next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default: next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi_wr_frontend.sv
// AXI write front end: pairs one AW burst with its W beats, emits per-beat
// scheduler requests through a one-entry output register, then returns B.
//
// state | meaning
// IDLE  | awready high, waiting for a burst address
// DATA  | accepting W beats and issuing per-beat requests
// RESP  | holding the B response until bready
module axi_wr_frontend
    import axi_wr_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_LEN   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [ADDR_LEN-1:0]     awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [ID_WIDTH-1:0]     wid,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    req_valid,
    input  logic                    req_ready,
    output logic [ID_WIDTH-1:0]     req_id,
    output logic [ADDR_WIDTH-1:0]   req_addr,
    output logic [DATA_WIDTH-1:0]   req_data,
    output logic [DATA_WIDTH/8-1:0] req_strb,
    output logic                    req_last
);

    localparam int         STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [2:0] MAX_SIZE   = 3'($clog2(STRB_WIDTH));

    state_t                state;
    state_t                state_next;
    logic [ID_WIDTH-1:0]   cap_id;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_LEN-1:0]   cap_len;
    logic [2:0]            cap_size;
    burst_t                cap_burst;
    logic [ADDR_LEN-1:0]   beat_cnt;
    logic                  beats_done;
    logic                  err;
    logic                  err_cap;
    logic                  cap_err_in;
    logic                  last_beat;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  req_hs;
    logic                  b_hs;

    assign aw_hs     = awvalid & awready;
    assign w_hs      = wvalid & wready;
    assign req_hs    = req_valid & req_ready;
    assign b_hs      = bvalid & bready;
    assign last_beat = (beat_cnt == cap_len);

    // WRAP needs a 2/4/8/16-beat burst: len nonzero and len+1 a power of two
    assign cap_err_in = (awburst == 2'b11)
                      || (awsize > MAX_SIZE)
                      || ((burst_t'(awburst) == WRAP)
                          && ((awlen == '0)
                              || ((awlen & (awlen + ADDR_LEN'(1))) != '0)));

    axi_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ADDR_LEN   (ADDR_LEN)
    ) u_addr_gen (
        .addr      (cur_addr),
        .size      (cap_size),
        .len       (cap_len),
        .burst     (cap_burst),
        .next_addr (next_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        awready    = 1'b0;
        wready     = 1'b0;
        case (state)
            IDLE: begin
                awready = 1'b1;
                if (awvalid) state_next = DATA;
            end
            DATA: begin
                // error bursts drain W without touching the output register
                wready = !beats_done && (err_cap || !req_valid || req_ready);
                if (err_cap) begin
                    if (wvalid && wready && last_beat) state_next = RESP;
                end else if (req_hs && req_last) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (b_hs) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_id     <= '0;
            cur_addr   <= '0;
            cap_len    <= '0;
            cap_size   <= '0;
            cap_burst  <= FIXED;
            beat_cnt   <= '0;
            beats_done <= 1'b0;
            err        <= 1'b0;
            err_cap    <= 1'b0;
            req_valid  <= 1'b0;
            req_id     <= '0;
            req_addr   <= '0;
            req_data   <= '0;
            req_strb   <= '0;
            req_last   <= 1'b0;
            bvalid     <= 1'b0;
            bid        <= '0;
            bresp      <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                cap_id     <= awid;
                cur_addr   <= awaddr;
                cap_len    <= awlen;
                cap_size   <= awsize;
                cap_burst  <= burst_t'(awburst);
                beat_cnt   <= '0;
                beats_done <= 1'b0;
                err        <= cap_err_in;
                err_cap    <= cap_err_in;
            end

            if (w_hs) begin
                if ((wlast != last_beat) || (wid != cap_id)) err <= 1'b1;
                beat_cnt <= beat_cnt + ADDR_LEN'(1);
                cur_addr <= next_addr;
                if (last_beat) beats_done <= 1'b1;
            end

            if (w_hs && !err_cap) begin
                req_valid <= 1'b1;
                req_id    <= cap_id;
                req_addr  <= cur_addr;
                req_data  <= wdata;
                req_strb  <= wstrb;
                req_last  <= last_beat;
            end else if (req_ready) begin
                req_valid <= 1'b0;
            end

            if (state == DATA && state_next == RESP) begin
                bvalid <= 1'b1;
                bid    <= cap_id;
                bresp  <= err ? RESP_SLVERR : RESP_OKAY;
            end else if (b_hs) begin
                bvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_wr_frontend.sv
// Directed bench for axi_wr_frontend: per-scenario tasks with inline checks.
module tb_axi_wr_frontend;

    localparam int AW = 32;
    localparam int IW = 4;
    localparam int DW = 128;
    localparam int SW = DW / 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          awvalid, awready;
    logic [IW-1:0] awid;
    logic [AW-1:0] awaddr;
    logic [LW-1:0] awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic          wvalid, wready;
    logic [IW-1:0] wid;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wlast;
    logic          bvalid, bready;
    logic [IW-1:0] bid;
    logic [1:0]    bresp;
    logic          req_valid, req_ready;
    logic [IW-1:0] req_id;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic [SW-1:0] req_strb;
    logic          req_last;

    always #5 clk = ~clk;

    axi_wr_frontend #(
        .ADDR_WIDTH (AW),
        .ID_WIDTH   (IW),
        .DATA_WIDTH (DW),
        .ADDR_LEN   (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .awvalid   (awvalid),
        .awready   (awready),
        .awid      (awid),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .awsize    (awsize),
        .awburst   (awburst),
        .wvalid    (wvalid),
        .wready    (wready),
        .wid       (wid),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .bvalid    (bvalid),
        .bready    (bready),
        .bid       (bid),
        .bresp     (bresp),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_id    (req_id),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_strb  (req_strb),
        .req_last  (req_last)
    );

    int tests = 0;
    int fails = 0;

    // results captured by run_burst
    logic [AW-1:0] q_addr[$];
    logic [DW-1:0] q_data[$];
    logic [SW-1:0] q_strb[$];
    logic          q_last[$];
    logic [IW-1:0] q_id[$];
    int            q_cyc[$];
    int            beats_acc, first_w_cyc, last_w_cyc, last_r_cyc, b_first, b_cycles;
    int            wready_bad, b_unstable, req_unstable;
    logic [IW-1:0] got_bid;
    logic [1:0]    got_bresp;
    bit            timed_out;

    function automatic logic [DW-1:0] mk_data(int id, int beat);
        logic [31:0] v;
        v = 32'(id * 256 + beat);
        return {32'h1111_0000 + v, 32'h2222_0000 + v, 32'h3333_0000 + v, 32'h4444_0000 + v};
    endfunction

    function automatic logic [SW-1:0] mk_strb(int beat);
        return SW'(16'h8001 + beat * 16'h0111);
    endfunction

    task automatic run_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                             input logic [2:0] size, input logic [1:0] burst, input int bad_last,
                             input bit toggle_rr, input int bready_delay, input bit cap_err);
        int cyc, beat, b_wait;
        bit exp_wr, done, prev_stall;
        logic [AW-1:0] prev_addr;
        logic [DW-1:0] prev_data;
        q_addr.delete(); q_data.delete(); q_strb.delete();
        q_last.delete(); q_id.delete(); q_cyc.delete();
        beats_acc = 0; first_w_cyc = -1; last_w_cyc = -1; last_r_cyc = -1;
        b_first = -1; b_cycles = 0; wready_bad = 0; b_unstable = 0; req_unstable = 0;
        got_bid = '0; got_bresp = '0; timed_out = 0;
        prev_stall = 0; prev_addr = '0; prev_data = '0;
        @(negedge clk);
        awvalid = 1'b1; awid = id; awaddr = addr; awlen = LW'(len); awsize = size; awburst = burst;
        cyc = 0;
        #1;
        while (!awready && cyc < 20) begin
            @(negedge clk); #1; cyc++;
        end
        if (!awready) timed_out = 1;
        @(negedge clk);
        awvalid = 1'b0;
        beat = 0; b_wait = 0; done = 0;
        for (cyc = 0; cyc < 300 && !done; cyc++) begin
            wvalid    = (beat <= len);
            wid       = id;
            wdata     = mk_data(id, beat);
            wstrb     = mk_strb(beat);
            wlast     = (beat == len) ^ (beat == bad_last);
            req_ready = toggle_rr ? (cyc % 2 == 0) : 1'b1;
            bready    = (b_wait >= bready_delay);
            #1;
            exp_wr = (beat <= len) && (cap_err || !req_valid || req_ready);
            if (wready !== exp_wr) wready_bad++;
            if (prev_stall && (req_valid !== 1'b1 || req_addr !== prev_addr || req_data !== prev_data))
                req_unstable++;
            prev_stall = req_valid && !req_ready;
            prev_addr  = req_addr;
            prev_data  = req_data;
            if (req_valid && req_ready) begin
                q_addr.push_back(req_addr); q_data.push_back(req_data); q_strb.push_back(req_strb);
                q_last.push_back(req_last); q_id.push_back(req_id); q_cyc.push_back(cyc);
                if (req_last) last_r_cyc = cyc;
            end
            if (wvalid && wready) begin
                if (first_w_cyc < 0) first_w_cyc = cyc;
                last_w_cyc = cyc;
                beat++;
                beats_acc++;
            end
            if (bvalid) begin
                if (b_first < 0) begin
                    b_first = cyc; got_bid = bid; got_bresp = bresp;
                end else if (bid !== got_bid || bresp !== got_bresp) begin
                    b_unstable++;
                end
                b_cycles++;
                if (bready) done = 1;
                b_wait++;
            end
            @(negedge clk);
        end
        if (!done) timed_out = 1;
        wvalid = 1'b0; bready = 1'b0; req_ready = 1'b0; wlast = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
        wvalid = 0; wid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0; req_ready = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        tests++; if (awready !== 1'b1) begin fails++; $display("FAIL reset_awready got %b exp 1", awready); end
        tests++; if (wready !== 1'b0) begin fails++; $display("FAIL reset_wready got %b exp 0", wready); end
        tests++; if (bvalid !== 1'b0) begin fails++; $display("FAIL reset_bvalid got %b exp 0", bvalid); end
        tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid got %b exp 0", req_valid); end
        tests++; if (bresp !== 2'b00 || bid !== '0) begin fails++; $display("FAIL reset_b got resp %b id %0h exp 0/0", bresp, bid); end
        tests++; if (req_addr !== '0 || req_data !== '0 || req_last !== 1'b0 || req_id !== '0 || req_strb !== '0)
            begin fails++; $display("FAIL reset_req got addr %0h last %b exp 0/0", req_addr, req_last); end
    endtask

    task automatic test_incr();
        run_burst(4'h5, 32'h100, 3, 3'd4, 2'b01, -1, 1'b0, 0, 1'b0);
        tests++; if (timed_out) begin fails++; $display("FAIL incr_timeout got 1 exp 0"); end
        tests++; if (q_addr.size() != 4) begin fails++; $display("FAIL incr_count got %0d exp 4", q_addr.size()); end
        for (int i = 0; i < q_addr.size() && i < 4; i++) begin
            tests++;
            if (q_addr[i] !== 32'h100 + 32'(16 * i) || q_data[i] !== mk_data(5, i) || q_strb[i] !== mk_strb(i)
                || q_last[i] !== (i == 3) || q_id[i] !== 4'h5 || q_cyc[i] !== q_cyc[0] + i) begin
                fails++;
                $display("FAIL incr_beat%0d got addr %0h last %b id %0h cyc %0d exp addr %0h last %b id 5 cyc %0d",
                         i, q_addr[i], q_last[i], q_id[i], q_cyc[i], 32'h100 + 32'(16 * i), (i == 3), q_cyc[0] + i);
            end
        end
        if (q_cyc.size() > 0) begin
            tests++; if (q_cyc[0] - first_w_cyc != 1) begin fails++; $display("FAIL incr_w2req_lat got %0d exp 1", q_cyc[0] - first_w_cyc); end
        end
        tests++; if (b_first - last_r_cyc != 1) begin fails++; $display("FAIL incr_b_lat got %0d exp 1", b_first - last_r_cyc); end
        tests++; if (got_bresp !== 2'b00 || got_bid !== 4'h5) begin fails++; $display("FAIL incr_b got resp %b id %0h exp 00 5", got_bresp, got_bid); end
        tests++; if (wready_bad != 0) begin fails++; $display("FAIL incr_wready got %0d bad cycles exp 0", wready_bad); end
        #1;
        tests++; if (awready !== 1'b1) begin fails++; $display("FAIL incr_awready_after got %b exp 1", awready); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_a [4];
        exp_a[0] = 32'h130; exp_a[1] = 32'h100; exp_a[2] = 32'h110; exp_a[3] = 32'h120;
        run_burst(4'h7, 32'h130, 3, 3'd4, 2'b10, -1, 1'b0, 0, 1'b0);
        tests++; if (q_addr.size() != 4 || timed_out) begin fails++; $display("FAIL wrap_count got %0d exp 4", q_addr.size()); end
        for (int i = 0; i < q_addr.size() && i < 4; i++) begin
            tests++;
            if (q_addr[i] !== exp_a[i] || q_data[i] !== mk_data(7, i)) begin
                fails++; $display("FAIL wrap_beat%0d got addr %0h exp %0h", i, q_addr[i], exp_a[i]);
            end
        end
        tests++; if (got_bresp !== 2'b00 || got_bid !== 4'h7) begin fails++; $display("FAIL wrap_b got resp %b id %0h exp 00 7", got_bresp, got_bid); end
    endtask

    task automatic test_fixed();
        run_burst(4'h2, 32'h40, 2, 3'd3, 2'b00, -1, 1'b0, 0, 1'b0);
        tests++; if (q_addr.size() != 3 || timed_out) begin fails++; $display("FAIL fixed_count got %0d exp 3", q_addr.size()); end
        for (int i = 0; i < q_addr.size() && i < 3; i++) begin
            tests++;
            if (q_addr[i] !== 32'h40 || q_data[i] !== mk_data(2, i) || q_strb[i] !== mk_strb(i) || q_last[i] !== (i == 2)) begin
                fails++; $display("FAIL fixed_beat%0d got addr %0h last %b exp 40 %b", i, q_addr[i], q_last[i], (i == 2));
            end
        end
        tests++; if (got_bresp !== 2'b00) begin fails++; $display("FAIL fixed_bresp got %b exp 00", got_bresp); end
    endtask

    task automatic test_back_to_back();
        run_burst(4'hA, 32'h200, 7, 3'd4, 2'b01, -1, 1'b1, 5, 1'b0);
        tests++; if (q_addr.size() != 8 || timed_out) begin fails++; $display("FAIL bp_count got %0d exp 8", q_addr.size()); end
        for (int i = 0; i < q_addr.size() && i < 8; i++) begin
            tests++;
            if (q_addr[i] !== 32'h200 + 32'(16 * i) || q_data[i] !== mk_data(10, i) || q_last[i] !== (i == 7)) begin
                fails++; $display("FAIL bp_beat%0d got addr %0h last %b exp %0h %b", i, q_addr[i], q_last[i], 32'h200 + 32'(16 * i), (i == 7));
            end
        end
        tests++; if (wready_bad != 0) begin fails++; $display("FAIL bp_wready got %0d bad cycles exp 0", wready_bad); end
        tests++; if (req_unstable != 0) begin fails++; $display("FAIL bp_req_stable got %0d changes exp 0", req_unstable); end
        tests++; if (b_first - last_r_cyc != 1) begin fails++; $display("FAIL bp_b_lat got %0d exp 1", b_first - last_r_cyc); end
        tests++; if (b_cycles != 6 || b_unstable != 0) begin fails++; $display("FAIL bp_b_hold got %0d cycles %0d changes exp 6 0", b_cycles, b_unstable); end
        tests++; if (got_bresp !== 2'b00 || got_bid !== 4'hA) begin fails++; $display("FAIL bp_b got resp %b id %0h exp 00 a", got_bresp, got_bid); end
    endtask

    task automatic test_rsvd_burst();
        run_burst(4'h9, 32'h80, 1, 3'd4, 2'b11, -1, 1'b0, 0, 1'b1);
        tests++; if (timed_out) begin fails++; $display("FAIL rsvd_timeout got 1 exp 0"); end
        tests++; if (beats_acc != 2) begin fails++; $display("FAIL rsvd_beats got %0d exp 2", beats_acc); end
        tests++; if (q_addr.size() != 0) begin fails++; $display("FAIL rsvd_reqs got %0d exp 0", q_addr.size()); end
        tests++; if (got_bresp !== 2'b10 || got_bid !== 4'h9) begin fails++; $display("FAIL rsvd_b got resp %b id %0h exp 10 9", got_bresp, got_bid); end
        tests++; if (b_first - last_w_cyc != 1) begin fails++; $display("FAIL rsvd_b_lat got %0d exp 1", b_first - last_w_cyc); end
        tests++; if (wready_bad != 0) begin fails++; $display("FAIL rsvd_wready got %0d bad cycles exp 0", wready_bad); end
    endtask

    task automatic test_wlast_err();
        run_burst(4'h3, 32'h500, 3, 3'd4, 2'b01, 1, 1'b0, 0, 1'b0);
        tests++; if (q_addr.size() != 4 || timed_out) begin fails++; $display("FAIL wlast_count got %0d exp 4", q_addr.size()); end
        for (int i = 0; i < q_addr.size() && i < 4; i++) begin
            tests++;
            if (q_last[i] !== (i == 3) || q_addr[i] !== 32'h500 + 32'(16 * i)) begin
                fails++; $display("FAIL wlast_beat%0d got addr %0h last %b exp %0h %b", i, q_addr[i], q_last[i], 32'h500 + 32'(16 * i), (i == 3));
            end
        end
        tests++; if (got_bresp !== 2'b10) begin fails++; $display("FAIL wlast_bresp got %b exp 10", got_bresp); end
    endtask

    task automatic test_reset_mid();
        int stray;
        @(negedge clk);
        awvalid = 1'b1; awid = 4'h3; awaddr = 32'h300; awlen = 4'd3; awsize = 3'd4; awburst = 2'b01;
        req_ready = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b1; wid = 4'h3; wdata = mk_data(3, 0); wstrb = mk_strb(0); wlast = 1'b0;
        @(negedge clk);
        wdata = mk_data(3, 1); wstrb = mk_strb(1);
        #1;
        tests++; if (req_valid !== 1'b1 || wready !== 1'b1) begin fails++; $display("FAIL rstmid_pre got req_valid %b wready %b exp 1 1", req_valid, wready); end
        @(negedge clk);
        wvalid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL rstmid_req_valid got %b exp 0", req_valid); end
        tests++; if (bvalid !== 1'b0) begin fails++; $display("FAIL rstmid_bvalid got %b exp 0", bvalid); end
        tests++; if (awready !== 1'b1 || wready !== 1'b0) begin fails++; $display("FAIL rstmid_ready got aw %b w %b exp 1 0", awready, wready); end
        stray = 0;
        repeat (4) begin
            @(negedge clk); #1;
            if (req_valid || bvalid) stray++;
        end
        tests++; if (stray != 0) begin fails++; $display("FAIL rstmid_stray got %0d exp 0", stray); end
        run_burst(4'h6, 32'h400, 1, 3'd4, 2'b01, -1, 1'b0, 0, 1'b0);
        tests++; if (q_addr.size() != 2 || timed_out) begin fails++; $display("FAIL rstmid_clean_count got %0d exp 2", q_addr.size()); end
        for (int i = 0; i < q_addr.size() && i < 2; i++) begin
            tests++;
            if (q_addr[i] !== 32'h400 + 32'(16 * i) || q_data[i] !== mk_data(6, i)) begin
                fails++; $display("FAIL rstmid_clean_beat%0d got addr %0h exp %0h", i, q_addr[i], 32'h400 + 32'(16 * i));
            end
        end
        tests++; if (got_bresp !== 2'b00 || got_bid !== 4'h6) begin fails++; $display("FAIL rstmid_clean_b got resp %b id %0h exp 00 6", got_bresp, got_bid); end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_fixed();
        test_back_to_back();
        test_rsvd_burst();
        test_wlast_err();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_wr_frontend.md
Name: axi_wr_frontend

Overview:
- Write-path front end of the DDR2 controller; sits directly downstream of the AXI write-address (AW), write-data (W) and write-response (B) interfaces.
- Accepts one AW burst at a time and pairs it with its W beats.
- Emits one per-beat write request (address, data, strobe) to the scheduler through a registered valid/ready port.
- Returns the B response once the burst's last request has been accepted downstream.

Parameters:
- ADDR_WIDTH, `AXI_ADDR_WIDTH (32), AXI byte address width
- ID_WIDTH, `AXI_ID_WIDTH (4), AXI transaction ID width
- DATA_WIDTH, `AXI_DATA_WIDTH, AXI data width in bits (power of two, ≥32)
- ADDR_LEN, 4, width of awlen (max burst = 2^ADDR_LEN beats)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- awvalid/awready  in/out  1/1  AW handshake
- awid  in  ID_WIDTH  burst ID
- awaddr  in  ADDR_WIDTH  start byte address
- awlen  in  ADDR_LEN  beats-1
- awsize  in  3  log2 bytes per beat
- awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- wvalid/wready  in/out  1/1  W handshake
- wid  in  ID_WIDTH  write data ID
- wdata  in  DATA_WIDTH  write data
- wstrb  in  DATA_WIDTH/8  byte strobes
- wlast  in  1  last beat marker
- bvalid/bready  out/in  1/1  B handshake
- bid  out  ID_WIDTH  response ID (= captured awid)
- bresp  out  2  00 OKAY, 10 SLVERR
- req_valid/req_ready  out/in  1/1  scheduler request handshake
- req_id  out  ID_WIDTH  burst ID
- req_addr  out  ADDR_WIDTH  beat byte address
- req_data  out  DATA_WIDTH  beat data
- req_strb  out  DATA_WIDTH/8  beat strobes
- req_last  out  1  final beat of burst

Behaviour:

Reset:
- State = IDLE.
- awready=1, wready=0, bvalid=0, req_valid=0.
- bresp=00, bid/req_* = 0, beat counter = 0, error flag = 0.
- Reset mid-burst discards the burst with no B response and no further requests.

State machine:
- IDLE:
  - awready=1.
  - On awvalid&awready: capture id/addr/len/size/burst, clear beat counter, go to DATA.
  - Error flag is set at capture if awburst=11 or awsize > log2(DATA_WIDTH/8).
- DATA:
  - awready=0.
  - wready = !req_valid | req_ready (one-entry output register; full throughput with req_ready held high).
  - Each W handshake loads the output register next cycle: req_valid=1, req_addr = current beat address, data/strb/id copied, req_last = (counter==len).
  - After each beat, the counter increments and the address advances.
- Error bursts:
  - W beats are still accepted (wready=1) but no request is issued.
- Address advance:
  - FIXED: unchanged.
  - INCR: addr + (1<<size).
  - WRAP: increment modulo boundary B = (len+1)<<size, i.e. addr = (addr & ~(B-1)) | ((addr + (1<<size)) & (B-1)).
  - WRAP with len not in {1,3,7,15} sets the error flag at capture.
- Beat count is authoritative:
  - wlast asserted on a beat other than beat len, or deasserted on beat len, sets the error flag.
  - The burst still ends after len+1 beats.
  - wid ≠ captured id sets the error flag; the beat is still forwarded.
- DATA→RESP:
  - Non-error burst: on the req handshake with req_last=1.
  - Error burst at capture: on acceptance of W beat number len.
  - Errors raised mid-burst (wlast/wid) do not suppress already-issued requests; they only set bresp.
- RESP:
  - bvalid=1 from the cycle after entry.
  - bid = captured id; bresp = 10 if error flag, else 00.
  - Outputs held stable until bready; then go to IDLE (awready=1 next cycle).
- Latency:
  - AW handshake at cycle N → wready earliest N+1.
  - W beat at cycle M → req_valid at M+1.
  - Last req handshake at K → bvalid at K+1.
- Outputs stay stable while valid and not ready (AXI rule).

Decomposition:
- Package axi_wr_pkg:
  - burst_t enum (FIXED/INCR/WRAP/RSVD)
  - resp codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - state_t enum (IDLE/DATA/RESP)
- Sub-module axi_burst_addr_gen (combinational next-address): inputs addr, size, len, burst; output next_addr.
- The sub-module is reused by the read-path front end.

Test Plan:
- INCR, awaddr=0x100, awlen=3, awsize=4, req_ready=1 → req_addr 0x100,0x110,0x120,0x130 on consecutive cycles; req_last on 4th; bresp=00, bid=awid.
- WRAP, awaddr=0x130, awlen=3, awsize=4 → req_addr 0x130,0x100,0x110,0x120; bresp=00.
- FIXED, awaddr=0x40, awlen=2 → three requests all at 0x40, data passed unchanged.
- INCR 8 beats with req_ready toggled 1-0 every cycle → wready tracks output register, no beat lost or duplicated, data order preserved; bvalid one cycle after final req handshake; bready held low 5 cycles → bvalid/bid/bresp stable.
- awburst=11, awlen=1 → 2 W beats accepted, req_valid never asserts, bresp=10.
- awlen=3 with wlast on beat 1 → 4 requests issued, bresp=10.
- rst asserted after 2nd beat → next cycle req_valid=0, bvalid=0, awready=1; a following clean burst completes normally.
